// File: rtl/glitch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : glitch_pkg
// Purpose : Shared types and constants for the clock-glitch trial sequencer.
//           Holds the sequencer state encoding, the post-glitch settle length
//           and the adder operand / sum widths.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package glitch_pkg;

  localparam int SETTLE_CYCLES = 2;
  localparam int SUM_W         = 5;
  localparam int OP_W          = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DELAY  = 3'd2,
    S_GLITCH = 3'd3,
    S_SETTLE = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } gs_state_t;

endpackage
`default_nettype wire

// File: rtl/glitch_down_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : glitch_down_counter
// Purpose : Loadable down-counter with a zero flag. A phase lasting N cycles
//           is timed by loading N-1 on entry and leaving when zero is seen.
// Ports   : clk_in1  - clock, rising edge
//           rst      - synchronous active-high reset
//           load     - load load_val (has priority over dec)
//           load_val - value to load
//           dec      - decrement by one (stops at zero)
//           zero     - count is zero
// Revision: 1.0 - initial release
// ============================================================================
module glitch_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_in1,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/glitch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : glitch_sequencer
// Purpose : Sequences clock-glitch trials against a 4-bit adder. Each trial
//           drives the operands, waits a delay, pulses glitch_en for a width,
//           settles, then compares the adder sum with the golden sum. The
//           delay is swept from delay_start to delay_end and faults counted.
// Ports   : clk_in1, rst           - clock / synchronous active-high reset
//           start, abort           - sweep control
//           op_a, op_b             - operands (latched at start)
//           delay_start, delay_end - sweep range (latched at start)
//           glitch_width           - pulse length (latched at start)
//           sum_in                 - adder result
//           a, b                   - operands to adder
//           glitch_en              - registered glitch clock select
//           busy, done             - sweep status
//           fault_cnt, fault_seen, first_fault_delay - results
// Revision: 1.0 - initial release
// ============================================================================
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int DELAY_W = 8,
  parameter int WIDTH_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_in1,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [OP_W-1:0]    op_a,
  input  logic [OP_W-1:0]    op_b,
  input  logic [DELAY_W-1:0] delay_start,
  input  logic [DELAY_W-1:0] delay_end,
  input  logic [WIDTH_W-1:0] glitch_width,
  input  logic [SUM_W-1:0]   sum_in,
  output logic [OP_W-1:0]    a,
  output logic [OP_W-1:0]    b,
  output logic               glitch_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   fault_cnt,
  output logic               fault_seen,
  output logic [DELAY_W-1:0] first_fault_delay
);

  localparam int CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  gs_state_t          r_state, w_next;
  logic [OP_W-1:0]    r_a, r_b;
  logic [DELAY_W-1:0] r_cur_delay, r_delay_end, r_first;
  logic [WIDTH_W-1:0] r_width;
  logic [CNT_W-1:0]   r_fault_cnt;
  logic               r_fault_seen, r_glitch_en;

  logic               w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [CW-1:0]      w_cnt_val;
  logic [DELAY_W-1:0] w_delay_m1;
  logic [WIDTH_W-1:0] w_width_m1;
  logic [SUM_W-1:0]   w_golden;
  logic               w_fault, w_last, w_start_ok, w_check_ok;

  assign w_delay_m1 = r_cur_delay - DELAY_W'(1);
  assign w_width_m1 = r_width - WIDTH_W'(1);
  // Full-width sum so a carry out (e.g. 15+15=30) is part of the comparison.
  assign w_golden   = SUM_W'(r_a) + SUM_W'(r_b);
  assign w_fault    = (sum_in != w_golden);
  // Compare before incrementing so an all-ones end delay never wraps.
  assign w_last     = (r_cur_delay >= r_delay_end);
  assign w_start_ok = (r_state == S_IDLE) && start && !abort;
  assign w_check_ok = (r_state == S_CHECK) && !abort;

  glitch_down_counter #(.W(CW)) u_cnt (
    .clk_in1  (clk_in1),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      S_IDLE: if (start && !abort) w_next = S_LOAD;
      S_LOAD: begin
        w_cnt_load = 1'b1;
        if (r_cur_delay != '0) begin
          w_next    = S_DELAY;
          w_cnt_val = CW'(w_delay_m1);
        end else if (r_width != '0) begin
          w_next    = S_GLITCH;
          w_cnt_val = CW'(w_width_m1);
        end else begin
          w_next    = S_SETTLE;
          w_cnt_val = CW'(SETTLE_CYCLES - 1);
        end
      end
      S_DELAY: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (r_width != '0) begin
          w_next     = S_GLITCH;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(w_width_m1);
        end else begin
          w_next     = S_SETTLE;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(SETTLE_CYCLES - 1);
        end
      end
      S_GLITCH: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_next     = S_SETTLE;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (!w_cnt_zero) w_cnt_dec = 1'b1;
        else             w_next    = S_CHECK;
      end
      S_CHECK: w_next = w_last ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_glitch_en <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Registered from the next state: high exactly while in GLITCH.
      r_glitch_en <= (w_next == S_GLITCH);
    end
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_cur_delay  <= '0;
      r_delay_end  <= '0;
      r_width      <= '0;
      r_fault_cnt  <= '0;
      r_fault_seen <= 1'b0;
      r_first      <= '0;
    end else if (w_start_ok) begin
      r_a          <= op_a;
      r_b          <= op_b;
      r_cur_delay  <= delay_start;
      r_delay_end  <= delay_end;
      r_width      <= glitch_width;
      r_fault_cnt  <= '0;
      r_fault_seen <= 1'b0;
      r_first      <= '0;
    end else if (w_check_ok) begin
      if (w_fault) begin
        if (r_fault_cnt != {CNT_W{1'b1}}) r_fault_cnt <= r_fault_cnt + CNT_W'(1);
        r_fault_seen <= 1'b1;
        if (!r_fault_seen) r_first <= r_cur_delay;
      end
      if (!w_last) r_cur_delay <= r_cur_delay + DELAY_W'(1);
    end
  end

  assign a                 = r_a;
  assign b                 = r_b;
  assign glitch_en         = r_glitch_en;
  assign busy              = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done              = (r_state == S_DONE);
  assign fault_cnt         = r_fault_cnt;
  assign fault_seen        = r_fault_seen;
  assign first_fault_delay = r_first;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_glitch_sequencer
// Purpose : Self-checking bench for glitch_sequencer. An adder model returns
//           the true sum except after a glitch pulse chosen by a per-trial
//           mask, where it returns 0. Expected sweep length, glitch cycles and
//           fault results are computed from the trial rules directly.
// Revision: 1.0 - initial release
// ============================================================================
module tb_glitch_sequencer;

  logic       clk_in1 = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0, start2 = 1'b0;
  logic [3:0] op_a = '0, op_b = '0, glitch_width = '0;
  logic [7:0] delay_start = '0, delay_end = '0;
  logic [4:0] sum_in;
  logic [3:0] a, b, a2, b2;
  logic       glitch_en, busy, done, fault_seen;
  logic       glitch_en2, busy2, done2, fault_seen2;
  logic [15:0] fault_cnt;
  logic [1:0]  fault_cnt2;
  logic [7:0]  first_fault_delay, first_fault_delay2;

  int checks = 0, errors = 0;

  always #5 clk_in1 = ~clk_in1;

  glitch_sequencer #(.DELAY_W(8), .WIDTH_W(4), .CNT_W(16)) dut (
    .clk_in1(clk_in1), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .delay_start(delay_start), .delay_end(delay_end),
    .glitch_width(glitch_width), .sum_in(sum_in), .a(a), .b(b),
    .glitch_en(glitch_en), .busy(busy), .done(done), .fault_cnt(fault_cnt),
    .fault_seen(fault_seen), .first_fault_delay(first_fault_delay)
  );

  // Second instance with a 2-bit counter; its adder always answers wrong.
  glitch_sequencer #(.DELAY_W(8), .WIDTH_W(4), .CNT_W(2)) dut_sat (
    .clk_in1(clk_in1), .rst(rst), .start(start2), .abort(1'b0),
    .op_a(op_a), .op_b(op_b), .delay_start(delay_start), .delay_end(delay_end),
    .glitch_width(glitch_width), .sum_in(5'd0), .a(a2), .b(b2),
    .glitch_en(glitch_en2), .busy(busy2), .done(done2), .fault_cnt(fault_cnt2),
    .fault_seen(fault_seen2), .first_fault_delay(first_fault_delay2)
  );

  // Adder model: the k-th glitch pulse of a sweep corrupts the sum if mask[k].
  bit [63:0] mask = '0;
  int        pidx = 0;
  logic      corrupt = 1'b0, prev_g = 1'b0;
  assign sum_in = corrupt ? 5'd0 : ({1'b0, a} + {1'b0, b});

  always @(negedge clk_in1) begin
    if (glitch_en && !prev_g) corrupt = 1'b0;
    if (!glitch_en && prev_g) begin
      corrupt = (pidx < 64) ? mask[pidx] : 1'b0;
      pidx++;
    end
    prev_g = glitch_en;
  end

  int m_busy, m_glitch, m_first_g, m_done, m_after_done, m_after_busy;
  bit m_timeout;

  // Starts a sweep, scrambles the inputs mid-sweep, and measures it to done.
  task automatic run_sweep(input logic [3:0] oa, input logic [3:0] ob,
                           input logic [7:0] ds, input logic [7:0] de,
                           input logic [3:0] w, input bit [63:0] msk);
    op_a = oa; op_b = ob; delay_start = ds; delay_end = de; glitch_width = w;
    mask = msk; pidx = 0; corrupt = 1'b0; start = 1'b1;
    @(negedge clk_in1);
    start = 1'b0;
    m_busy = 0; m_glitch = 0; m_first_g = -1; m_done = 0; m_timeout = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2) begin
        op_a = 4'($urandom); op_b = 4'($urandom); glitch_width = 4'($urandom);
        delay_start = 8'($urandom); delay_end = 8'($urandom);
      end
      if (done) begin m_done = 1; m_timeout = 1'b0; break; end
      if (busy) m_busy++;
      if (glitch_en) begin m_glitch++; if (m_first_g < 0) m_first_g = i; end
      @(negedge clk_in1);
    end
    @(negedge clk_in1);
    m_after_done = int'(done);
    m_after_busy = int'(busy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in1);
    checks++;
    if ({a, b, glitch_en, busy, done, fault_cnt, fault_seen, first_fault_delay} !== '0) begin
      errors++; $display("FAIL reset_outputs got a=%0d b=%0d g=%0b busy=%0b done=%0b cnt=%0d seen=%0b ffd=%0d want all 0",
                         a, b, glitch_en, busy, done, fault_cnt, fault_seen, first_fault_delay);
    end
    rst = 1'b0;
    @(negedge clk_in1);
  endtask

  task automatic test_single_trial();
    run_sweep(4'd5, 4'd3, 8'd0, 8'd0, 4'd1, '0);
    checks++; if (m_timeout) begin errors++; $display("FAIL single_timeout got no done want done"); end
    checks++; if (m_busy != 5) begin errors++; $display("FAIL single_busy got %0d want 5", m_busy); end
    checks++; if (m_glitch != 1 || m_first_g != 1) begin errors++; $display("FAIL single_glitch got %0d@%0d want 1@1", m_glitch, m_first_g); end
    checks++; if (m_after_done != 0) begin errors++; $display("FAIL single_done_pulse got done held want one cycle"); end
    checks++; if (fault_cnt !== 16'd0 || fault_seen !== 1'b0) begin errors++; $display("FAIL single_faults got %0d/%0b want 0/0", fault_cnt, fault_seen); end
    checks++; if (a !== 4'd5 || b !== 4'd3) begin errors++; $display("FAIL single_operands got %0d,%0d want 5,3", a, b); end
  endtask

  task automatic test_clean_sweep();
    run_sweep(4'd10, 4'd5, 8'd2, 8'd4, 4'd1, '0);
    checks++; if (m_timeout || m_busy != 24) begin errors++; $display("FAIL clean_busy got %0d (timeout %0b) want 24", m_busy, m_timeout); end
    checks++; if (m_glitch != 3 || m_first_g != 3) begin errors++; $display("FAIL clean_glitch got %0d@%0d want 3@3", m_glitch, m_first_g); end
    checks++; if (fault_cnt !== 16'd0 || fault_seen !== 1'b0) begin errors++; $display("FAIL clean_faults got %0d/%0b want 0/0", fault_cnt, fault_seen); end
  endtask

  task automatic test_fault_capture();
    run_sweep(4'd15, 4'd15, 8'd1, 8'd5, 4'd2, 64'b100);
    checks++; if (m_timeout) begin errors++; $display("FAIL fault_timeout got no done want done"); end
    checks++; if (m_glitch != 10) begin errors++; $display("FAIL fault_glitch got %0d want 10", m_glitch); end
    checks++; if (fault_cnt !== 16'd1 || fault_seen !== 1'b1) begin errors++; $display("FAIL fault_count got %0d/%0b want 1/1", fault_cnt, fault_seen); end
    checks++; if (first_fault_delay !== 8'd3) begin errors++; $display("FAIL fault_first got %0d want 3", first_fault_delay); end
    repeat (4) @(negedge clk_in1);
    checks++; if (fault_cnt !== 16'd1 || first_fault_delay !== 8'd3) begin errors++; $display("FAIL fault_hold got %0d/%0d want 1/3", fault_cnt, first_fault_delay); end
  endtask

  task automatic test_reversed_width0();
    run_sweep(4'd6, 4'd7, 8'd6, 8'd2, 4'd0, '1);
    checks++; if (m_timeout || m_busy != 10) begin errors++; $display("FAIL reversed_busy got %0d (timeout %0b) want 10", m_busy, m_timeout); end
    checks++; if (m_glitch != 0) begin errors++; $display("FAIL reversed_glitch got %0d want 0", m_glitch); end
    checks++; if (fault_cnt !== 16'd0) begin errors++; $display("FAIL reversed_faults got %0d want 0", fault_cnt); end
  endtask

  task automatic test_abort_reset();
    bit seen = 1'b0;
    op_a = 4'd2; op_b = 4'd3; delay_start = 8'd3; delay_end = 8'd5; glitch_width = 4'd3;
    mask = '0; pidx = 0; corrupt = 1'b0; start = 1'b1;
    @(negedge clk_in1);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (glitch_en) begin seen = 1'b1; break; end
      @(negedge clk_in1);
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort_reach_glitch got no glitch want glitch"); end
    abort = 1'b1;
    @(negedge clk_in1);
    abort = 1'b0;
    checks++; if (glitch_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_stop got g=%0b busy=%0b done=%0b want 0/0/0", glitch_en, busy, done); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk_in1);
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done got activity want idle"); end

    op_a = 4'd7; op_b = 4'd9; delay_start = 8'd5; delay_end = 8'd6; glitch_width = 4'd1;
    start = 1'b1;
    @(negedge clk_in1);
    start = 1'b0;
    repeat (2) @(negedge clk_in1);
    checks++; if (busy !== 1'b1 || a !== 4'd7) begin errors++; $display("FAIL rst_pre_busy got busy=%0b a=%0d want 1/7", busy, a); end
    rst = 1'b1;
    @(negedge clk_in1);
    checks++;
    if ({a, b, glitch_en, busy, done, fault_cnt, fault_seen, first_fault_delay} !== '0) begin
      errors++; $display("FAIL rst_mid_sweep got a=%0d b=%0d g=%0b busy=%0b done=%0b cnt=%0d want all 0",
                         a, b, glitch_en, busy, done, fault_cnt);
    end
    rst = 1'b0;
    run_sweep(4'd4, 4'd4, 8'd0, 8'd1, 4'd1, '0);
    checks++; if (m_timeout || m_busy != 11) begin errors++; $display("FAIL rst_fresh_sweep got %0d (timeout %0b) want 11", m_busy, m_timeout); end
  endtask

  task automatic test_saturation();
    bit got_done = 1'b0;
    op_a = 4'd1; op_b = 4'd1; delay_start = 8'd0; delay_end = 8'd4; glitch_width = 4'd1;
    start2 = 1'b1;
    @(negedge clk_in1);
    start2 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (done2) begin got_done = 1'b1; break; end
      @(negedge clk_in1);
    end
    checks++; if (!got_done) begin errors++; $display("FAIL sat_timeout got no done want done"); end
    checks++; if (fault_cnt2 !== 2'd3 || fault_seen2 !== 1'b1 || first_fault_delay2 !== 8'd0) begin
      errors++; $display("FAIL sat_count got %0d/%0b/%0d want 3/1/0", fault_cnt2, fault_seen2, first_fault_delay2); end
    repeat (5) @(negedge clk_in1);
    checks++; if (fault_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", fault_cnt2); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int ds, de, w, n, exp_busy, exp_faults, exp_first, exp_first_g;
      bit [63:0] msk;
      logic [3:0] oa, ob;
      ds = int'($urandom_range(0, 5)); de = int'($urandom_range(0, 8));
      w  = int'($urandom_range(0, 3));
      oa = 4'($urandom); ob = 4'($urandom);
      msk = {$urandom, $urandom};
      n = (de < ds) ? 1 : de - ds + 1;
      exp_busy = 0; exp_faults = 0; exp_first = 0;
      for (int t = 0; t < n; t++) begin
        exp_busy += 4 + ds + t + w;
        if (w > 0 && msk[t]) begin
          if (exp_faults == 0) exp_first = ds + t;
          exp_faults++;
        end
      end
      exp_first_g = (w > 0) ? 1 + ds : -1;
      run_sweep(oa, ob, 8'(ds), 8'(de), 4'(w), msk);
      checks++; if (m_timeout || m_busy != exp_busy) begin errors++; $display("FAIL rand%0d_busy got %0d want %0d", it, m_busy, exp_busy); end
      checks++; if (m_glitch != n * w || m_first_g != exp_first_g) begin
        errors++; $display("FAIL rand%0d_glitch got %0d@%0d want %0d@%0d", it, m_glitch, m_first_g, n * w, exp_first_g); end
      checks++; if (int'(fault_cnt) != exp_faults || fault_seen !== (exp_faults > 0) || int'(first_fault_delay) != exp_first) begin
        errors++; $display("FAIL rand%0d_faults got %0d/%0b/%0d want %0d/%0b/%0d", it, fault_cnt, fault_seen,
                           first_fault_delay, exp_faults, exp_faults > 0, exp_first); end
      checks++; if (m_after_done != 0 || m_after_busy != 0) begin errors++; $display("FAIL rand%0d_end got done=%0d busy=%0d want 0/0", it, m_after_done, m_after_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single_trial();
    test_clean_sweep();
    test_fault_capture();
    test_reversed_width0();
    test_abort_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glitch_sequencer.md
# glitch_sequencer

Controller that sequences clock-glitch trials against the 4-bit adder datapath (operands `a`/`b`, 5-bit sum `finout`). For each trial it:
- drives the operands,
- waits a programmable delay,
- asserts `glitch_en` for a programmable width (the clock-mux select in the top level),
- lets the adder settle, then compares the captured sum against a golden sum.

It sweeps the delay over a range and reports fault statistics. It sits between the host/register interface and the glitch clock mux plus adder.

## Interface
Parameters:
- `DELAY_W`, 8, width of delay fields (cycles)
- `WIDTH_W`, 4, width of glitch-width field (cycles)
- `CNT_W`, 16, width of fault counter

Ports:
- `clk_in1`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin sweep; sampled only in IDLE
- `abort`  in  1  terminate sweep; no `done`
- `op_a`  in  4  operand A latched at start
- `op_b`  in  4  operand B latched at start
- `delay_start`  in  DELAY_W  first trial delay, latched at start
- `delay_end`  in  DELAY_W  last trial delay, latched at start
- `glitch_width`  in  WIDTH_W  glitch pulse length, latched at start
- `sum_in`  in  5  adder result (`finout`)
- `a`  out  4  operand to adder
- `b`  out  4  operand to adder
- `glitch_en`  out  1  glitch clock select, registered
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep completion
- `fault_cnt`  out  CNT_W  mismatching trials, saturating
- `fault_seen`  out  1  at least one fault this sweep
- `first_fault_delay`  out  DELAY_W  delay of first faulting trial

## Operation
States: IDLE, LOAD, DELAY, GLITCH, SETTLE, CHECK, DONE.

- **IDLE:** `busy`=0.
  - `start`=1 → latch inputs, set `cur_delay`=`delay_start`, clear `fault_cnt`/`fault_seen`/`first_fault_delay` → LOAD.
- **LOAD:** 1 cycle; `a`/`b` driven from latched operands.
  - → DELAY if `cur_delay`>0.
  - else → GLITCH if `glitch_width`>0.
  - else → SETTLE.
- **DELAY:** `cur_delay` cycles, then → GLITCH (or SETTLE if width=0).
- **GLITCH:** `glitch_en`=1 for exactly `glitch_width` cycles → SETTLE.
- **SETTLE:** `SETTLE_CYCLES`=2 cycles, `glitch_en`=0.
- **CHECK:** 1 cycle.
  - Golden = `{1'b0,a}+{1'b0,b}`, 5-bit, no truncation.
  - `sum_in`≠golden → `fault_cnt`++ (saturate at all-ones) and `fault_seen`=1.
  - If it is the first fault, `first_fault_delay`=`cur_delay`.
  - Then, if `cur_delay`≥`delay_end` → DONE; else `cur_delay`++ → LOAD.
- **DONE:** `done`=1, `busy`=0, 1 cycle → IDLE. Results hold until the next `start`.

Boundary rules:
- `delay_end` < `delay_start` → exactly one trial at `delay_start`.
- `delay_end`=all-ones → last trial at all-ones; `cur_delay` does not wrap.
- `abort` in any non-IDLE state → IDLE at next edge, `glitch_en`=0, no `done`, results retain partial values.
- `abort` and `start` together in IDLE → `start` ignored.
- `start` outside IDLE is ignored.
- Latched inputs are immune to input changes mid-sweep.

## Timing
- Reset values: state IDLE, `a`=0, `b`=0, `glitch_en`=0, `busy`=0, `done`=0, `fault_cnt`=0, `fault_seen`=0, `first_fault_delay`=0.
- Reset mid-sweep: all outputs at reset values from the edge sampling `rst`=1.
- `start` sampled at edge E → LOAD in cycle after E; `busy`=1 from that cycle.
- Trial length = 1 + d + w + 2 + 1 cycles (LOAD, DELAY, GLITCH, SETTLE, CHECK).
- `done` is asserted the cycle after the final CHECK.
- `glitch_en` is a flop output: rises on the edge entering GLITCH, falls on the edge leaving it. No combinational path from any input.
- `sum_in` is sampled at the CHECK edge only.
- Counters update at the CHECK edge and are visible the next cycle.

## Structure
- Shared package `glitch_pkg`:
  - state enum `gs_state_t`
  - `SETTLE_CYCLES`=2
  - `SUM_W`=5
  - `OP_W`=4
- One sub-module `glitch_down_counter`: loadable down-counter with zero flag, reused for the DELAY, GLITCH and SETTLE phases.
- Sequencer FSM and result registers live in `glitch_sequencer`.

## Test plan
- **Single trial:** reset, then `op_a`=5, `op_b`=3, `delay_start`=`delay_end`=0, `glitch_width`=1, `sum_in` model correct (8) → `glitch_en` high 1 cycle; `busy` high 5 cycles; `done` pulse; `fault_cnt`=0.
- **Clean sweep:** `op_a`=10, `op_b`=5, delay 2..4, width 1, correct model → `busy` high 7+8+9=24 cycles, then `done`; `fault_cnt`=0, `fault_seen`=0.
- **Fault capture:** `op_a`=15, `op_b`=15, delay 1..5, width 2; bench model returns 0 when the glitch ended at delay 3 → `fault_cnt`=1, `fault_seen`=1, `first_fault_delay`=3; golden 30 (5'b11110) with no truncation.
- **Reversed range and width 0:** `delay_start`=6, `delay_end`=2, width 0 → one trial, `glitch_en` never asserted, `busy` 10 cycles.
- **Abort and reset mid-sweep:** `abort` during GLITCH → `glitch_en`=0 and `busy`=0 next cycle, no `done`. Then `rst` during DELAY of a new sweep → all outputs at reset values; `start` in the next cycle begins a fresh sweep.
- **Saturation:** `CNT_W`=2, 5 faulting trials → `fault_cnt`=3, held.
